// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Receives a byte stream (LEN_HI, LEN_LO, N big-endian words, optional checksum),
// writes the words sequentially into instruction memory, and then releases the
// CPU from reset. The CPU stays in reset during the load and after any error.
// Optional feature macro: IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DHI    = 3'd2,
    S_DLO    = 3'd3,
`ifdef IMEM_LOADER_CHKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                accept;
  logic [15:0]         len_full;
  logic [ADDR_W:0]     words_inc;

  // Ready is a pure decode of the registered state, so no in_valid -> in_ready path exists.
  always_comb begin
    in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  end

  assign accept    = in_valid & in_ready;
  assign len_full  = {len_hi_q, in_data};
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state and datapath updates; status flags are derived from the next state
  // so that cpu_rst drops on the same edge as the final write (or checksum accept).
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    hi_d      = hi_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_LEN_HI: if (accept) begin
        len_hi_d = in_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        if (len_full == 16'd0 || len_full > 16'(DEPTH)) begin
          state_d = S_ERR;
        end else begin
          len_d   = len_full[ADDR_W:0];
          state_d = S_DHI;
        end
      end
      S_DHI: if (accept) begin
        hi_d    = in_data;
`ifdef IMEM_LOADER_CHKSUM_EN
        csum_d  = csum_q ^ in_data;
`endif
        state_d = S_DLO;
      end
      S_DLO: if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = words_q[ADDR_W-1:0];
        wr_data_d = DATA_W'({hi_q, in_data});
        words_d   = words_inc;
`ifdef IMEM_LOADER_CHKSUM_EN
        csum_d    = csum_q ^ in_data;
        state_d   = (words_inc == len_q) ? S_CSUM : S_DHI;
`else
        state_d   = (words_inc == len_q) ? S_DONE : S_DHI;
`endif
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      S_CSUM: if (accept) begin
        state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    cpu_rst_d = (state_d != S_DONE);
  end

  // State and output registers; async reset returns everything to the idle/boot values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LEN_HI;
      len_hi_q  <= '0;
      len_q     <= '0;
      hi_q      <= '0;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      words_q   <= words_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cpu_rst = cpu_rst_q;
  assign words   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level model derives every expected
// output from the list of accepted bytes; directed tests add literal expectations.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_rst, done, err;
  logic [ADDR_W:0]   words;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst(cpu_rst), .done(done), .err(err), .words(words)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stream-level model ----------------
  logic [7:0] acc[$];
  logic       pend = 1'b0;
  logic [7:0] pend_b = 8'h00;
  logic       just;
  int         nn, d, w;
  logic [7:0] x;
  logic       e_ready, e_done, e_err, e_wr;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  int         e_words;

  always @(negedge clk) begin
    if (rst) begin
      acc.delete();
      pend = 1'b0;
      just = 1'b0;
    end else begin
      just = pend;
      if (pend) acc.push_back(pend_b);
    end
    e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_wr = 1'b0;
    e_words = 0; e_addr = '0; e_data = '0;
    if (acc.size() >= 2) begin
      nn = {acc[0], acc[1]};
      if (nn == 0 || nn > DEPTH) e_err = 1'b1;
      else begin
        d = acc.size() - 2;
        w = (d / 2 > nn) ? nn : d / 2;
        e_words = w;
        if (just && d > 0 && d % 2 == 0 && d / 2 <= nn) begin
          e_wr   = 1'b1;
          e_addr = ADDR_W'(w - 1);
          e_data = {acc[acc.size()-2], acc[acc.size()-1]};
        end
        if (w == nn) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          if (d == 2 * nn + 1) begin
            x = 8'h00;
            for (int i = 2; i < 2 + 2 * nn; i++) x = x ^ acc[i];
            if (acc[acc.size()-1] == x) e_done = 1'b1;
            else e_err = 1'b1;
          end
`else
          e_done = 1'b1;
`endif
        end
      end
    end
    if (e_done || e_err) e_ready = 1'b0;
    check("in_ready", in_ready, e_ready);
    check("done", done, e_done);
    check("err", err, e_err);
    check("cpu_rst", cpu_rst, !e_done);
    check("words", words, e_words);
    check("wr_en", wr_en, e_wr);
    if (e_wr) begin
      check("wr_addr", wr_addr, e_addr);
      check("wr_data", wr_data, e_data);
    end else if (e_words == 0) begin
      check("wr_addr_idle", wr_addr, 0);
      check("wr_data_idle", wr_data, 0);
    end
    pend   = in_valid && e_ready && !rst;
    pend_b = in_data;
  end

  // ---------------- write log for literal checks ----------------
  logic [ADDR_W-1:0] log_a[$];
  logic [DATA_W-1:0] log_d[$];
  int                log_c[$];
  int                fall_cyc = -1;
  logic              cpu_prev = 1'b1;

  always @(negedge clk) begin
    if (wr_en) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
      log_c.push_back(cyc);
    end
    if (!rst && cpu_prev && !cpu_rst) fall_cyc = cyc;
    cpu_prev = cpu_rst;
  end

  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_c.delete(); fall_cyc = -1;
  endtask

  // ---------------- drivers (time kept at posedge+1) ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_words", words, 0);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   n;
    in_valid = 1'b1; in_data = b;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk) ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    in_valid = 1'b0; in_data = 8'hxx;
  endtask

  task automatic send(input logic [7:0] s[$], input bit thr);
    foreach (s[i]) begin
      if (thr) begin
        repeat ($urandom_range(0, 2)) begin
          in_data = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      send_byte(s[i]);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  logic [7:0] s[$];

  initial begin
    // Basic load
    do_reset();
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHKSUM_EN
    s.push_back(8'h40);
`endif
    send(s, 1'b0);
    settle();
    check("basic_nwr", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("basic_a0", log_a[0], 0);  check("basic_d0", log_d[0], 16'h1234);
      check("basic_a1", log_a[1], 1);  check("basic_d1", log_d[1], 16'hABCD);
      check("basic_gap", log_c[1] - log_c[0], 2);
    end
    check("basic_done", done, 1);
    check("basic_cpu_rst", cpu_rst, 0);
    check("basic_words", words, 2);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Bad checksum
    do_reset();
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send(s, 1'b0);
    settle();
    check("badcs_err", err, 1);
    check("badcs_cpu_rst", cpu_rst, 1);
    check("badcs_ready", in_ready, 0);
    check("badcs_done", done, 0);
`endif

    // Illegal lengths: zero and DEPTH+1
    do_reset();
    s = '{8'h00, 8'h00};
    send(s, 1'b0);
    settle();
    check("len0_err", err, 1);
    check("len0_words", words, 0);
    check("len0_nwr", log_a.size(), 0);
    do_reset();
    s = '{8'h01, 8'h01};
    send(s, 1'b0);
    settle();
    check("len257_err", err, 1);
    check("len257_ready", in_ready, 0);
    check("len257_nwr", log_a.size(), 0);

    // Throttled 4-word load
    do_reset();
    s = '{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
`ifdef IMEM_LOADER_CHKSUM_EN
    s.push_back(8'h00);
`endif
    send(s, 1'b1);
    settle();
    check("thr_nwr", log_a.size(), 4);
    if (log_a.size() == 4) begin
      check("thr_a3", log_a[3], 3);
      check("thr_d2", log_d[2], 16'h3333);
    end
    check("thr_done", done, 1);

    // Reset mid-load
    do_reset();
    s = '{8'h00, 8'h03, 8'h12};
    send(s, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_words", words, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHKSUM_EN
    s.push_back(8'h51);
`endif
    send(s, 1'b0);
    settle();
    check("fresh_nwr", log_a.size(), 1);
    if (log_a.size() == 1) begin
      check("fresh_a0", log_a[0], 0);
      check("fresh_d0", log_d[0], 16'hBEEF);
    end
    check("fresh_done", done, 1);

    // Full depth, data = address
    do_reset();
    s = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'h00);
      s.push_back(8'(i));
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    s.push_back(8'h00);
`endif
    send(s, 1'b0);
    settle();
    check("full_nwr", log_a.size(), 256);
    if (log_a.size() == 256) begin
      check("full_last_a", log_a[255], 8'hFF);
      check("full_last_d", log_d[255], 16'h00FF);
`ifdef IMEM_LOADER_CHKSUM_EN
      check("full_fall", fall_cyc, log_c[255] + 1);
`else
      check("full_fall", fall_cyc, log_c[255]);
`endif
    end
    check("full_words", words, 256);
    check("full_done", done, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
